// File: rtl/tqvp_spike_decoder.sv
// Spike-stream decoder: integrates a synchronized pulse/polarity train into an 8-bit intensity with leak toward a baseline.
// Define SPIKE_DEC_FIFO_EN to build the 4-entry sample FIFO and the STATUS register.
module tqvp_spike_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    logic [1:0] sync1_reg, sync2_reg;
    logic       edge_reg;
    logic [7:0] recon_reg, recon_next;
    logic [7:0] step_reg, leak_reg, base_reg, evcnt_reg;
    logic [7:0] leak_cnt_reg, leak_cnt_next;
    logic       spike_event, spike_up, leak_tc;
    logic       wr_recon, wr_step, wr_leak, wr_base, wr_evcnt;
    logic [8:0] sum_up, diff_down;
    logic [7:0] up_val, down_val, leak_val;
    logic [7:0] fifo_head, status;
    logic       unused_ok;

    assign unused_ok = &{1'b0, ui_in[7:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 2'b00;
            sync2_reg <= 2'b00;
            edge_reg  <= 1'b0;
        end else begin
            sync1_reg <= ui_in[1:0];
            sync2_reg <= sync1_reg;
            edge_reg  <= sync2_reg[0];
        end
    end

    assign spike_event = sync2_reg[0] & ~edge_reg;
    assign spike_up    = sync2_reg[1];

    assign wr_recon = data_write && (address == 4'h0);
    assign wr_step  = data_write && (address == 4'h1);
    assign wr_leak  = data_write && (address == 4'h2);
    assign wr_base  = data_write && (address == 4'h3);
    assign wr_evcnt = data_write && (address == 4'h4);

    // 9-bit arithmetic; the top bit flags overflow (up) or borrow (down)
    assign sum_up    = {1'b0, recon_reg} + {1'b0, step_reg};
    assign diff_down = {1'b0, recon_reg} - {1'b0, step_reg};
    assign up_val    = sum_up[8] ? 8'hFF : sum_up[7:0];
    assign down_val  = diff_down[8] ? 8'h00 : diff_down[7:0];

    always_comb begin
        leak_val = recon_reg;
        if (recon_reg < base_reg)
            leak_val = recon_reg + 8'd1;
        else if (recon_reg > base_reg)
            leak_val = recon_reg - 8'd1;
    end

    assign leak_tc = (leak_reg != 8'd0) && (leak_cnt_reg == (leak_reg - 8'd1));

    // CPU write beats an event, which beats a leak step
    always_comb begin
        recon_next = recon_reg;
        if (wr_recon)
            recon_next = data_in;
        else if (spike_event)
            recon_next = spike_up ? up_val : down_val;
        else if (leak_tc)
            recon_next = leak_val;
    end

    always_comb begin
        leak_cnt_next = leak_cnt_reg + 8'd1;
        if (wr_leak || (leak_reg == 8'd0) || leak_tc)
            leak_cnt_next = 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recon_reg    <= 8'd0;
            step_reg     <= 8'd20;
            leak_reg     <= 8'd0;
            base_reg     <= 8'd0;
            evcnt_reg    <= 8'd0;
            leak_cnt_reg <= 8'd0;
        end else begin
            recon_reg    <= recon_next;
            leak_cnt_reg <= leak_cnt_next;
            if (wr_step)
                step_reg <= data_in;
            if (wr_leak)
                leak_reg <= data_in;
            if (wr_base)
                base_reg <= data_in;
            if (wr_evcnt)
                evcnt_reg <= 8'd0;
            else if (spike_event)
                evcnt_reg <= evcnt_reg + 8'd1;
        end
    end

`ifdef SPIKE_DEC_FIFO_EN
    logic [7:0] fifo_mem [0:3];
    logic [1:0] rd_ptr_reg, wr_ptr_reg;
    logic [2:0] count_reg, count_next;
    logic       ovf_reg;
    logic       pop_ok, push_ok, ovf_set, wr_status;

    assign pop_ok    = data_write && (address == 4'h5) && (count_reg != 3'd0);
    // a pop in the same cycle frees the slot that a push into a full FIFO needs
    assign push_ok   = spike_event && ((count_reg != 3'd4) || pop_ok);
    assign ovf_set   = spike_event && !push_ok;
    assign wr_status = data_write && (address == 4'h6);

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + 3'd1;
        else if (pop_ok && !push_ok)
            count_next = count_reg - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= recon_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= 2'd0;
            wr_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            ovf_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            if (ovf_set)
                ovf_reg <= 1'b1;
            else if (wr_status)
                ovf_reg <= 1'b0;
        end
    end

    assign fifo_head = (count_reg == 3'd0) ? 8'd0 : fifo_mem[rd_ptr_reg];
    assign status    = {2'b00, ovf_reg, (count_reg == 3'd4), (count_reg == 3'd0), count_reg};
`else
    assign fifo_head = 8'd0;
    assign status    = 8'd0;
`endif

    always_comb begin
        data_out = 8'd0;
        case (address)
            4'h0: data_out = recon_reg;
            4'h1: data_out = step_reg;
            4'h2: data_out = leak_reg;
            4'h3: data_out = base_reg;
            4'h4: data_out = evcnt_reg;
            4'h5: data_out = fifo_head;
            4'h6: data_out = status;
            default: data_out = 8'd0;
        endcase
    end

    assign uo_out = recon_reg;

endmodule

// File: doc/tqvp_spike_decoder.md
# tqvp_spike_decoder

Spike-stream decoder peripheral for the TinyQV user-peripheral slot, the receive end of the spike edge-detector link. It takes an external spike train (pulse plus polarity) on `ui_in`, integrates it into a reconstructed 8-bit pixel intensity with programmable step size and leak toward a baseline, and drives the reconstruction on `uo_out`. Per-event samples are buffered in a 4-entry FIFO for the CPU to read over the peripheral register bus.

## Interface
- `FIFO_DEPTH`, 4: sample FIFO entries. Fixed; not a module parameter.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low. Clock is `clk`.
- `ui_in` in 8: bit 0 is the spike pulse, asynchronous and active-high. Bit 1 is polarity (1 = up, 0 = down). Bits 7:2 are ignored.
- `uo_out` out 8: reconstructed intensity (RECON register). Reset value 0.
- `address` in 4: register address.
- `data_write` in 1: single-cycle write strobe.
- `data_in` in 8: write data.
- `data_out` out 8: read data. Combinational from `address`. Unmapped addresses read 0.

## Operation
- Register map:
  - 0x0 RECON, R/W, reset 0.
  - 0x1 STEP, R/W, reset 20.
  - 0x2 LEAK, R/W, reset 0. 0 disables leak.
  - 0x3 BASE, R/W, reset 0.
  - 0x4 EVCNT, R, reset 0. A write of any value clears it.
  - 0x5 FIFO_HEAD, R. Returns the oldest entry, or 0 when empty. A write of any value pops one entry.
  - 0x6 STATUS, R. Bits [2:0] = fill count (0..4), bit 3 = empty, bit 4 = full, bit 5 = sticky overflow, bits [7:6] = 0. A write of any value clears overflow.
- Input path:
  - `ui_in[1:0]` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - An event is a rising edge on the synchronized bit 0.
  - Polarity is taken from the synchronized bit 1 in the same pipeline stage.
- On an event:
  - RECON becomes sat(RECON + STEP) for up, or sat(RECON − STEP) for down.
  - Arithmetic is 9-bit, clamped to 0..255.
  - EVCNT increments, wrapping 255 → 0.
  - The new RECON value is pushed into the FIFO.
- Leak:
  - When LEAK ≠ 0, a cycle counter runs 0..LEAK−1.
  - On terminal count, RECON moves 1 toward BASE (no change if equal) and the counter restarts at 0.
  - Leak does not push to the FIFO.
- Simultaneous events:
  - Event and leak terminal count in the same cycle: the event wins, the leak step is dropped and the counter restarts.
  - CPU write to RECON and an event in the same cycle: the CPU value wins. EVCNT still increments, and the FIFO pushes the written value.
  - Writing LEAK restarts the leak counter at 0.
- FIFO:
  - Push while full with no pop: the sample is dropped and overflow is set. Contents are unchanged.
  - Push and pop in the same cycle when full: the pop is applied, then the push. No overflow.
  - Pop when empty: ignored.
  - Push and pop in the same cycle when empty: the push is applied and the pop is ignored.
- Reset mid-operation: all registers, synchronizer flops, the leak counter, FIFO pointers, count and overflow return to reset values immediately.

## Timing
- Event latency:
  - Edge E0 is the first `clk` edge that samples `ui_in[0]` high.
  - RECON, `uo_out`, EVCNT and the FIFO update at edge E2.
  - RECON is readable on `data_out` after E2.
- Pulse width: `ui_in[0]` must be high for at least 1 full cycle and low for at least 1 full cycle between events. Shorter pulses may be lost.
- Maximum event rate: 1 event per 2 cycles.
- Register writes take effect on the `clk` edge where `data_write` is high. A FIFO pop is visible on `data_out` in the next cycle.
- Leak with LEAK = N: one step every N cycles when no events occur.

## Configuration
- `SPIKE_DEC_FIFO_EN` defined:
  - FIFO and STATUS are implemented as described above.
- Not defined:
  - No FIFO storage is built.
  - Addresses 0x5 and 0x6 read 0, and writes to them are ignored.
  - RECON, EVCNT and leak behaviour are unchanged.

## Test plan
- Reset, then read all registers → RECON 0, STEP 20, LEAK 0, BASE 0, EVCNT 0, STATUS 0x08, `uo_out` 0.
- 3 up pulses with STEP = 100 → RECON sequence 100, 200, 255 (saturated). EVCNT = 3. FIFO holds 100, 200, 255.
- RECON = 10, STEP = 20, 1 down pulse → RECON 0. Check that `uo_out` changes exactly at E2 of the pulse.
- BASE = 50, RECON = 53, LEAK = 4, no events → RECON 52, 51, 50, 50 at 4-cycle intervals.
- 5 pulses without any pop → STATUS fill count 4, full = 1, overflow = 1. The 5th sample is absent. 4 pops return samples 1–4, then STATUS = 0x28. A write to 0x6 clears overflow.
- Pulse edge at E2 coinciding with a CPU write RECON = 77 → RECON 77, EVCNT +1, FIFO tail 77.
